mul_div_unit: RTL

//  Iterative multiply/divide unit in the EX stage, beside the ALU. Fed by regfile rd1/rd2 (forwarded).

---
 rtl/mul_div_unit_pkg.sv | 37 +++
 rtl/mul_div_unit_if.sv | 30 +++
 rtl/mdu_negate.sv | 11 +
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Op codes, FSM states and the HI/LO related funct codes.
package mul_div_unit_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Command and HI/LO result bundle between EX stage and the MDU.
// master drives commands, slave is the unit itself.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, flush,
        output we_hi, we_lo, wd,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, flush,
        input  we_hi, we_lo, wd,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation.
// Used for operand magnitudes and result sign fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? ((~x) + WIDTH'(1)) : x;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// WIDTH iterations of shift-add / restoring divide, then sign fix.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH;

    mdu_state_e       state, state_nx;
    logic [CW-1:0]    count;
    logic [DW-1:0]    acc;
    logic [WIDTH-1:0] opd;
    logic             q_neg, r_neg;
    logic             div_op, dz;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             launch, commit;

    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign sgn = op_signed(bus.op);

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
        .x   (bus.a),
        .neg (sgn & bus.a[WIDTH-1]),
        .y   (mag_a)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
        .x   (bus.b),
        .neg (sgn & bus.b[WIDTH-1]),
        .y   (mag_b)
    );

    // Multiply: add multiplicand into upper half, shift right.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   msum;
    logic [DW-1:0]    mul_nx;

    assign addend = acc[0] ? opd : '0;
    assign msum   = {1'b0, acc[DW-1:WIDTH]} + {1'b0, addend};
    assign mul_nx = {msum, acc[WIDTH-1:1]};

    // Divide: upper half is remainder, lower half shifts quotient in.
    logic [WIDTH:0]   part, diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [DW-1:0]    div_nx;

    assign part   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    assign diff   = part - {1'b0, opd};
    assign qbit   = ~diff[WIDTH];
    assign rem_nx = qbit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    assign div_nx = {rem_nx, acc[WIDTH-2:0], qbit};

    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    mdu_negate #(.WIDTH(DW)) u_fix_p (
        .x   (acc),
        .neg (q_neg),
        .y   (prod_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_fix_q (
        .x   (acc[WIDTH-1:0]),
        .neg (q_neg),
        .y   (quo_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_fix_r (
        .x   (acc[DW-1:WIDTH]),
        .neg (r_neg),
        .y   (rem_fix)
    );

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        commit   = 1'b0;
        unique case (state)
            MDU_IDLE: begin
                if (bus.start && !bus.flush) begin
                    launch   = 1'b1;
                    state_nx = MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (bus.flush)
                    state_nx = MDU_IDLE;
                else if (count == CW'(WIDTH - 1))
                    state_nx = MDU_FIX;
            end
            MDU_FIX: begin
                state_nx = MDU_IDLE;
                commit   = !bus.flush;
            end
            default: state_nx = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= MDU_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opd    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            div_op <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (state == MDU_IDLE) begin
                if (bus.we_hi) hi_q <= bus.wd;
                if (bus.we_lo) lo_q <= bus.wd;
            end
            if (launch) begin
                div_op <= op_div(bus.op);
                q_neg  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg  <= sgn & bus.a[WIDTH-1];
                dz     <= op_div(bus.op) & (bus.b == '0);
                opd    <= op_div(bus.op) ? mag_b : mag_a;
                acc    <= {{WIDTH{1'b0}},
                           op_div(bus.op) ? mag_a : mag_b};
                count  <= '0;
            end else if (state == MDU_CALC) begin
                acc   <= div_op ? div_nx : mul_nx;
                count <= count + CW'(1);
            end
            if (commit) begin
                if (div_op) begin
                    hi_q <= rem_fix;
                    lo_q <= dz ? '1 : quo_fix;
                end else begin
                    hi_q <= prod_fix[DW-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != MDU_IDLE);
    assign bus.done = done_q;

endmodule
